// File: rtl/axis_rr_arbiter_4to1.sv
// Packet-aware round-robin arbiter for a 4:1 AXI-Stream mux.
// Holds a grant until end-of-packet or a beat-limit forced release.
module axis_rr_arbiter_4to1 #(
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       valid_0,
  input  logic       valid_1,
  input  logic       valid_2,
  input  logic       valid_3,
  input  logic       last_0,
  input  logic       last_1,
  input  logic       last_2,
  input  logic       last_3,
  input  logic       ready,
  output logic [1:0] sel,
  output logic       active,
  output logic [3:0] grant,
  output logic       timeout
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_BEATS);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       vld;
  logic [3:0]       lst;
  logic             beat;
  logic             hit_max;
  logic             found;
  logic [1:0]       pick;
  logic [CNT_W:0]   cnt_inc;

  assign vld     = {valid_3, valid_2, valid_1, valid_0};
  assign lst     = {last_3, last_2, last_1, last_0};
  assign beat    = active & vld[sel] & ready;
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign hit_max = (MAX_BEATS != 0) && (cnt_inc == MAX_C);

  // Scan ptr+1 .. ptr+4 so the last granted source is checked last
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int i = 1; i <= 4; i++) begin
      if (!found && vld[ptr + 2'(i)]) begin
        found = 1'b1;
        pick  = ptr + 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= 2'd0;
      active  <= 1'b0;
      grant   <= 4'b0000;
      timeout <= 1'b0;
      cnt     <= '0;
      ptr     <= 2'd3;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && found) begin
            state  <= LOCKED;
            sel    <= pick;
            active <= 1'b1;
            grant  <= 4'b0001 << pick;
            cnt    <= '0;
          end
        end
        LOCKED: begin
          if (beat) begin
            cnt <= (&cnt) ? cnt : cnt_inc[CNT_W-1:0];
            if (lst[sel] || hit_max) begin
              state   <= IDLE;
              active  <= 1'b0;
              grant   <= 4'b0000;
              ptr     <= sel;
              cnt     <= '0;
              timeout <= ~lst[sel];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter_4to1.sv
// Bench for axis_rr_arbiter_4to1: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_axis_rr_arbiter_4to1;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] v;
  logic [3:0] l;
  logic       ready;
  logic [1:0] sel;
  logic       active;
  logic [3:0] grant;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_act;
  int m_sel;
  int m_ptr;
  int m_cnt;
  bit m_to;

  always #5 clk = ~clk;

  axis_rr_arbiter_4to1 #(.MAX_BEATS(MAXB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en),
    .valid_0(v[0]), .valid_1(v[1]), .valid_2(v[2]), .valid_3(v[3]),
    .last_0(l[0]), .last_1(l[1]), .last_2(l[2]), .last_3(l[3]),
    .ready(ready), .sel(sel), .active(active), .grant(grant),
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_act = 0; m_sel = 0; m_ptr = 3; m_cnt = 0; m_to = 0;
  endtask

  // One clock of the arbitration rules, applied to the inputs seen at the edge
  task automatic m_step();
    bit done;
    m_to = 0;
    if (!m_act) begin
      done = 0;
      if (en) begin
        for (int i = 1; i <= 4; i++) begin
          int k;
          k = (m_ptr + i) % 4;
          if (!done && v[k]) begin
            done = 1; m_sel = k; m_act = 1; m_cnt = 0;
          end
        end
      end
    end else if (v[m_sel] && ready) begin
      m_cnt++;
      if (l[m_sel]) begin
        m_act = 0; m_ptr = m_sel; m_cnt = 0;
      end else if (m_cnt == MAXB) begin
        m_act = 0; m_ptr = m_sel; m_cnt = 0; m_to = 1;
      end
    end
  endtask

  task automatic chk_all(input string tag);
    logic [3:0] eg;
    eg = m_act ? (4'b0001 << m_sel) : 4'b0000;
    chk({tag, "_sel"}, {2'b00, sel}, 4'(m_sel));
    chk({tag, "_active"}, {3'b000, active}, {3'b000, m_act});
    chk({tag, "_grant"}, grant, eg);
    chk({tag, "_timeout"}, {3'b000, timeout}, {3'b000, m_to});
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    #1;
    chk_all(tag);
  endtask

  initial begin
    int got_q[$];
    int exp_q[6];
    int to_cnt;
    bit prev;

    exp_q = '{0, 1, 2, 3, 0, 1};
    rst = 1; en = 1; v = 4'hF; l = 4'h0; ready = 1;
    m_reset();

    // reset held with every source requesting
    repeat (3) cyc("rst");
    chk("rst_grant", grant, 4'b0000);
    rst = 0; v = 4'h0;
    cyc("idle");

    // single source, 3-beat packet
    v = 4'b0100;
    cyc("t2_req");
    chk("t2_grant", grant, 4'b0100);
    cyc("t2_b1");
    cyc("t2_b2");
    l = 4'b0100;
    cyc("t2_b3");
    chk("t2_rel", {3'b000, active}, 4'h0);
    v = 4'h0; l = 4'h0;
    cyc("t2_idle");

    // fairness after a fresh reset
    rst = 1; cyc("t3_rst"); rst = 0;
    v = 4'hF; l = 4'hF; prev = 0;
    for (int i = 0; i < 12; i++) begin
      cyc("t3");
      if (active && !prev) got_q.push_back(sel);
      prev = active;
    end
    for (int i = 0; i < 6; i++)
      chk("t3_order", 4'(got_q[i]), 4'(exp_q[i]));
    v = 4'h0; l = 4'h0;
    cyc("t3_end");

    // backpressure on source 1
    v = 4'b0010;
    cyc("t4_req");
    cyc("t4_b1");
    ready = 0;
    for (int i = 0; i < 5; i++) begin
      cyc("t4_hold");
      chk("t4_grant", grant, 4'b0010);
    end
    ready = 1; l = 4'b0010;
    cyc("t4_b2");
    chk("t4_rel", {3'b000, active}, 4'h0);
    v = 4'h0; l = 4'h0;
    cyc("t4_idle");

    // forced release on source 3, source 0 waiting
    rst = 1; cyc("t5_rst"); rst = 0;
    v = 4'b1000;
    cyc("t5_req");
    chk("t5_grant", grant, 4'b1000);
    v = 4'b1001; to_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc("t5");
      if (timeout) to_cnt++;
    end
    chk("t5_pulses", 4'(to_cnt), 4'd1);
    chk("t5_next", grant, 4'b0001);
    l = 4'b0001;
    cyc("t5_done");
    v = 4'h0; l = 4'h0;
    cyc("t5_idle");

    // en low mid-packet, then async reset mid-packet
    v = 4'b0100;
    cyc("t6_req");
    en = 0;
    cyc("t6_b1");
    l = 4'b0100;
    cyc("t6_b2");
    v = 4'hF; l = 4'h0;
    repeat (3) cyc("t6_off");
    chk("t6_noreq", grant, 4'b0000);
    en = 1;
    cyc("t6_req2");
    cyc("t6_beat");
    rst = 1;
    #1;
    m_reset();
    chk_all("t6_async");
    cyc("t6_rst");
    rst = 0;
    cyc("t6_src0");
    chk("t6_grant0", grant, 4'b0001);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      v     = 4'($urandom);
      l     = 4'($urandom) & 4'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 199) == 0);
      cyc("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
